// File: rtl/keccak_stream_padder.sv
// Streaming Keccak/SHA-3 padder.
// Packs W-bit message words into RATE-bit blocks. It applies multi-rate padding
// (pad10*1) with a run-time domain-separation byte, and hands each block to the
// permutation front end.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in, in_valid      message word (byte 0 in in[W-1 -: 8]) and its valid
//   in_last, in_bytes final word flag and its valid byte count (0..W/8)
//   dsbyte            domain-separation byte (0x06 SHA3, 0x1F SHAKE)
//   in_ready          a word is accepted this cycle when in_valid && in_ready
//   out, out_valid    block (byte k in out[RATE-1-8k -: 8]) and its valid
//   out_last          block is the final block of the message
//   out_ack           consumer took the block presented on out
module keccak_stream_padder #(
  parameter int unsigned W    = 64,
  parameter int unsigned RATE = 576,
  parameter int unsigned BW   = $clog2(W / 8 + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    in,
  input  logic            in_valid,
  input  logic            in_last,
  input  logic [BW-1:0]   in_bytes,
  input  logic [7:0]      dsbyte,
  output logic            in_ready,
  output logic [RATE-1:0] out,
  output logic            out_valid,
  output logic            out_last,
  input  logic            out_ack
);

  localparam int unsigned WPB = RATE / W;
  localparam int unsigned NB  = W / 8;
  localparam int unsigned RB  = RATE / 8;
  localparam int unsigned CW  = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int unsigned PW  = $clog2(RB + 1);

  typedef enum logic [0:0] {StFill, StFull} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            last_q, last_d;
  logic [7:0]      dsb_q, dsb_d;
  logic [RATE-1:0] buf_q, buf_d;

  logic [PW-1:0]   pad_pos;
  logic [W-1:0]    word_masked;
  logic            accept;

  // Byte offset of the domain-separation byte within the block.
  assign pad_pos = PW'(cnt_q) * PW'(NB) + PW'(in_bytes);
  assign accept  = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFill;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
      dsb_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      dsb_q   <= dsb_d;
      buf_q   <= buf_d;
    end
  end

  // Last word with bytes at index >= in_bytes cleared.
  always_comb begin
    word_masked = '0;
    for (int b = 0; b < int'(NB); b++) begin
      if (BW'(b) < in_bytes) begin
        word_masked[W-1-8*b -: 8] = in[W-1-8*b -: 8];
      end
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    last_d  = last_q;
    dsb_d   = dsb_q;
    buf_d   = buf_q;

    unique case (state_q)
      StFill: begin
        if (accept && !in_last) begin
          for (int i = 0; i < int'(WPB); i++) begin
            if (CW'(i) == cnt_q) begin
              buf_d[RATE-1-W*i -: W] = in;
            end
          end
          if (cnt_q == CW'(WPB - 1)) begin
            state_d = StFull;
            cnt_d   = '0;
            last_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (accept) begin
          // Rebuild the whole block so nothing past the last word survives.
          buf_d = '0;
          for (int i = 0; i < int'(WPB); i++) begin
            if (CW'(i) < cnt_q) begin
              buf_d[RATE-1-W*i -: W] = buf_q[RATE-1-W*i -: W];
            end else if (CW'(i) == cnt_q) begin
              buf_d[RATE-1-W*i -: W] = word_masked;
            end
          end
          if (pad_pos < PW'(RB)) begin
            for (int k = 0; k < int'(RB); k++) begin
              if (pad_pos == PW'(k)) begin
                buf_d[RATE-1-8*k -: 8] = buf_d[RATE-1-8*k -: 8] | dsbyte;
              end
            end
            buf_d[7:0] = buf_d[7:0] | 8'h80;
            last_d     = 1'b1;
            pend_d     = 1'b0;
          end else begin
            // Block exactly full: padding goes into an extra block.
            last_d = 1'b0;
            pend_d = 1'b1;
            dsb_d  = dsbyte;
          end
          state_d = StFull;
          cnt_d   = '0;
        end
      end
      StFull: begin
        if (out_ack && pend_q) begin
          buf_d              = '0;
          buf_d[RATE-1 -: 8] = dsb_q;
          buf_d[7:0]         = buf_d[7:0] | 8'h80;
          last_d             = 1'b1;
          pend_d             = 1'b0;
        end else if (out_ack) begin
          buf_d   = '0;
          last_d  = 1'b0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == StFill) && !rst;
    out_valid = (state_q == StFull);
    out_last  = last_q;
    out       = buf_q;
  end

endmodule

// File: tb/tb_keccak_stream_padder.sv
module tb_keccak_stream_padder;

  localparam int W    = 64;
  localparam int RATE = 576;
  localparam int RB   = RATE / 8;
  localparam int BW   = $clog2(W / 8 + 1);

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [RATE-1:0] blk;
    logic            last;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [W-1:0]    in = '0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic [BW-1:0]   in_bytes = '0;
  logic [7:0]      dsbyte = 8'h06;
  logic            in_ready;
  logic [RATE-1:0] out;
  logic            out_valid;
  logic            out_last;
  logic            out_ack = 1'b0;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  keccak_stream_padder #(.W(W), .RATE(RATE)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_bytes (in_bytes),
    .dsbyte   (dsbyte),
    .in_ready (in_ready),
    .out      (out),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ack  (out_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [RATE-1:0] act, input logic [RATE-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference padding: pad10*1 on a byte stream, split into RB-byte blocks.
  task automatic expect_msg(input bq_t msg, input logic [7:0] dsb);
    bq_t p;
    exp_t e;
    int nblk;
    p = msg;
    p.push_back(dsb);
    while (p.size() % RB != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    nblk = p.size() / RB;
    for (int b = 0; b < nblk; b++) begin
      e.blk = '0;
      for (int k = 0; k < RB; k++) e.blk[RATE-1-8*k -: 8] = p[b*RB+k];
      e.last = (b == nblk - 1);
      sb.push_back(e);
    end
  endtask

  function automatic bq_t mk_msg(input int n, input int seed);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(seed + i * 13));
    return q;
  endfunction

  // Scoreboard monitor: compares every block at the handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_block", {575'd0, out_valid}, '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("block_data", out, e.blk);
        chk("block_last", {575'd0, out_last}, {575'd0, e.last});
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [W-1:0] w, input logic last, input int nbytes);
    int t;
    in       = w;
    in_valid = 1'b1;
    in_last  = last;
    in_bytes = BW'(nbytes);
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("in_ready_timeout", '0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Bytes past the message end are filled with 0xEE to exercise masking.
  task automatic send_msg(input bq_t msg);
    int n, nw, nb;
    logic [W-1:0] w;
    n  = msg.size();
    nw = (n == 0) ? 1 : (n + 7) / 8;
    for (int i = 0; i < nw; i++) begin
      for (int j = 0; j < 8; j++) w[W-1-8*j -: 8] = (i * 8 + j < n) ? msg[i*8+j] : 8'hEE;
      nb = (i == nw - 1) ? n - i * 8 : 8;
      send_word(w, i == nw - 1, nb);
    end
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("out_valid_timeout", '0, 1);
  endtask

  // Waits for a block, holds off the ack for 'hold' cycles while checking
  // that the block is stable, then acks. Returns 1 time unit after the ack edge.
  task automatic ack_one(input int hold);
    logic [RATE-1:0] snap;
    wait_valid();
    snap = out;
    for (int h = 0; h < hold; h++) begin
      chk("hold_in_ready", {575'd0, in_ready}, '0);
      chk("hold_out_stable", out, snap);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ack = 1'b1;
    @(posedge clk);
    #1 out_ack = 1'b0;
  endtask

  initial begin
    bq_t m;

    // Reset state
    #2;
    chk("rst_out", out, '0);
    chk("rst_out_valid", {575'd0, out_valid}, '0);
    chk("rst_out_last", {575'd0, out_last}, '0);
    chk("rst_in_ready", {575'd0, in_ready}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post_rst_in_ready", {575'd0, in_ready}, 1);
    @(posedge clk);
    #1;

    // Empty message
    dsbyte = 8'h06;
    m = mk_msg(0, 0);
    expect_msg(m, 8'h06);
    send_msg(m);
    wait_valid();
    chk("empty_byte0", {568'd0, out[575:568]}, {568'd0, 8'h06});
    chk("empty_byte71", {568'd0, out[7:0]}, {568'd0, 8'h80});
    ack_one(0);

    // 3-byte message
    m = {};
    m.push_back(8'hAA); m.push_back(8'hBB); m.push_back(8'hCC);
    expect_msg(m, 8'h06);
    send_msg(m);
    wait_valid();
    chk("b3_head", {544'd0, out[575:544]}, {544'd0, 32'hAABBCC06});
    chk("b3_tail", {568'd0, out[7:0]}, {568'd0, 8'h80});
    ack_one(0);

    // 71 bytes: pad and final bit share byte 71
    m = mk_msg(71, 5);
    expect_msg(m, 8'h06);
    send_msg(m);
    wait_valid();
    chk("b71_byte71", {568'd0, out[7:0]}, {568'd0, 8'h86});
    ack_one(0);

    // 72 bytes: data block then a pad-only block with no valid gap
    m = mk_msg(72, 9);
    expect_msg(m, 8'h06);
    send_msg(m);
    wait_valid();
    chk("b72_first_last", {575'd0, out_last}, '0);
    ack_one(0);
    chk("b72_valid_kept", {575'd0, out_valid}, 1);
    chk("b72_second_last", {575'd0, out_last}, 1);
    chk("b72_pad_byte0", {568'd0, out[575:568]}, {568'd0, 8'h06});
    ack_one(0);

    // SHAKE, 2 bytes, ack delayed 5 cycles
    dsbyte = 8'h1F;
    m = mk_msg(2, 40);
    expect_msg(m, 8'h1F);
    send_msg(m);
    wait_valid();
    chk("shake_byte2", {568'd0, out[559:552]}, {568'd0, 8'h1F});
    ack_one(5);
    chk("shake_in_ready_after_ack", {575'd0, in_ready}, 1);

    // 80-byte SHAKE message spanning two blocks; fill resumes after drain
    m = mk_msg(80, 77);
    expect_msg(m, 8'h1F);
    fork
      send_msg(m);
      begin
        ack_one(2);
        ack_one(0);
      end
    join
    dsbyte = 8'h06;

    // Reset mid-message after 4 words
    for (int i = 0; i < 4; i++) send_word({8{8'h5A}}, 1'b0, 8);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", {575'd0, in_ready}, '0);
    chk("abort_out", out, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    m = mk_msg(3, 100);
    expect_msg(m, 8'h06);
    send_msg(m);
    ack_one(0);

    // Reset while a block is presented drops it at once
    m = mk_msg(10, 3);
    send_msg(m);
    wait_valid();
    rst = 1'b1;
    #1;
    chk("abort_full_valid", {575'd0, out_valid}, '0);
    chk("abort_full_out", out, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    m = mk_msg(9, 200);
    expect_msg(m, 8'h06);
    send_msg(m);
    ack_one(0);

    repeat (3) @(posedge clk);
    chk("sb_drained", RATE'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
